reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset sequencer that synchronises an asynchronous active-low board reset and a PLL lock indication to `i_clk`, then releases `NUM_OUTPUTS` synchronous active-high resets strictly in order. Each stage has its own release delay and must be acknowledged by its downstream block before the next stage starts. Any lock loss or software reset request re-asserts every output and restarts the sequence. The block sits at the top of each FPGA clock domain and feeds the per-subsystem reset trees.

## Interface
- `NUM_OUTPUTS`, 4: number of sequenced reset outputs (1..16).
- `DELAY_W`, 16: width of each per-stage delay field.
- `STAGE_DELAYS`, '0: packed `NUM_OUTPUTS*DELAY_W` vector; field k (bits `k*DELAY_W +: DELAY_W`) is stage k's release delay D[k].
- `LOCK_FILTER_CYCLES`, 16: consecutive locked cycles required before sequencing (>=1).
- `SW_RST_MIN_CYCLES`, 8: minimum cycles all outputs are held in the ASSERT state (>=1).
- `ACK_TIMEOUT_CYCLES`, 1024: stage acknowledge timeout; used only with the watchdog macro.
- `i_clk`  in  1  sequencer clock.
- `i_ext_arst_n`  in  1  external reset. Asynchronous, active-low.
- `i_pll_locked`  in  1  PLL lock. Asynchronous to `i_clk`.
- `i_sw_rst_req`  in  1  synchronous, level-sensitive software reset request.
- `i_stage_ack`  in  NUM_OUTPUTS  per-stage "out of reset and ready" acknowledge.
- `o_sync_resets`  out  NUM_OUTPUTS  active-high resets, registered.
- `o_all_released`  out  1  high in RUN only.
- `o_state`  out  3  current state encoding from the package.
- `o_fault`  out  1  sticky ack-timeout flag.
- `o_fault_stage`  out  4  stage index of the most recent timeout.

## Operation
- Reset values, async on `i_ext_arst_n`=0: `o_sync_resets`='1, `o_all_released`=0, `o_state`=HOLD, `o_fault`=0, `o_fault_stage`=0. All counters = 0.
- Release of `i_ext_arst_n` goes through a 2-flop synchroniser with async assertion. Internal logic is held at reset values until the synchronised release.
- `i_pll_locked` goes through a 2-flop synchroniser to produce `lock_s`.
- States:
  - HOLD: all outputs asserted. Counts consecutive `lock_s`=1 cycles; the counter clears on `lock_s`=0. When the count reaches `LOCK_FILTER_CYCLES`, go to DELAY with stage k=0.
  - DELAY: lasts D[k]+1 cycles. On exit, `o_sync_resets[k]` deasserts and the state moves to WAIT_ACK.
  - WAIT_ACK: leave when `i_stage_ack[k]` is sampled high.
    - If k<N-1: k increments and the state returns to DELAY.
    - If k=N-1: go to RUN.
    - Acks from other stages are ignored.
  - RUN: `o_all_released`=1. Outputs of released stages stay deasserted.
  - ASSERT: all outputs asserted. Lasts `SW_RST_MIN_CYCLES`; the counter restarts every cycle `i_sw_rst_req`=1. Exits to HOLD with the lock filter cleared.
- Abort: `lock_s`=0 or `i_sw_rst_req`=1 in DELAY, WAIT_ACK or RUN sends the state to ASSERT. Every output is asserted on the next edge.
  - Abort takes priority over all other transitions in the same cycle.
  - Lock loss and a software request in the same cycle produce one ASSERT entry.
  - In HOLD, `i_sw_rst_req` clears the lock filter.
- Outputs only deassert one at a time, in index order. Re-assertion is simultaneous for all outputs.
- Counters saturate and never wrap. A delay counter of `DELAY_W` bits plus one extra bit covers D+1.

## Timing
- From `i_ext_arst_n` rising with the PLL locked to `o_sync_resets[0]` falling: 2 (arst sync) + `LOCK_FILTER_CYCLES` + D[0]+1 cycles. The lock synchroniser is already settled at that point.
- `i_stage_ack[k]` high at edge n starts DELAY[k+1] at edge n+1.
- Abort is sampled at edge n; all outputs read 1 after edge n+1.
- Lock loss is seen 2 cycles late, through the synchroniser.
- `o_state`, `o_all_released` and the fault outputs are registered and aligned with `o_sync_resets`.

## Configuration
- `RESET_SEQ_ACK_TIMEOUT_EN` defined:
  - In WAIT_ACK, a counter measures the wait. Reaching `ACK_TIMEOUT_CYCLES` without an ack sets `o_fault`=1 and `o_fault_stage`=k, then enters ASSERT, so the whole sequence retries.
  - `o_fault` clears only on `i_ext_arst_n`.
- Undefined: WAIT_ACK waits indefinitely, and `o_fault`/`o_fault_stage` are tied to 0.

## Structure
- `reset_seq_pkg` holds:
  - `reset_seq_state_t` enum, 3 bits: HOLD=0, DELAY=1, WAIT_ACK=2, RUN=3, ASSERT=4.
  - A `MAX_OUTPUTS`=16 constant.
- One sub-module, `cdc_sync2`: a 2-flop synchroniser with a parameterised reset value.
  - Instanced for `i_pll_locked` (reset 0).
  - Instanced for the release of `i_ext_arst_n` (reset 0, D tied 1).

## Test plan
- N=3, D={2,0,5}, filter=4, acks tied 1. Release reset with lock high → outputs fall at cycles 9, 11, 18 after release, then `o_all_released`=1.
- Hold `i_stage_ack[1]`=0 for 50 cycles → `o_sync_resets[2]` stays 1. Raise ack → stage 2 falls D[2]+1=6 cycles later.
- Drop `i_pll_locked` in RUN → all outputs 1 after 3 cycles. Re-lock → sequence repeats from HOLD with identical timing.
- Pulse `i_sw_rst_req` for 1 cycle in WAIT_ACK → ASSERT for exactly 8 cycles, then HOLD.
  - Hold the request 20 cycles → ASSERT lasts 20+8 cycles.
- With `RESET_SEQ_ACK_TIMEOUT_EN` and `ACK_TIMEOUT_CYCLES`=64, never ack stage 1 → `o_fault`=1 and `o_fault_stage`=1 after 64 cycles, and the retry sequence starts.
- Assert `i_ext_arst_n`=0 mid-DELAY → all outputs 1 immediately (asynchronous), and `o_fault` clears.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding and limits for the reset sequencer.
// Types only; no logic, no latency, no flow control.
package reset_seq_pkg;

  localparam int unsigned MAX_OUTPUTS = 16;
  localparam int unsigned STAGE_W     = $clog2(MAX_OUTPUTS);

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    DELAY    = 3'd1,
    WAIT_ACK = 3'd2,
    RUN      = 3'd3,
    ASSERT   = 3'd4
  } reset_seq_state_t;

endpackage

// File: rtl/reset_sequencer_cdc_sync2.sv
// Two-flop synchroniser with async reset to RST_VAL.
// Latency 2 cycles; no flow control, samples every cycle.
module cdc_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_OUTPUTS resets in order after lock filter, per-stage delay and downstream ack; aborts re-assert all.
// Outputs registered; stages wait on i_stage_ack indefinitely unless RESET_SEQ_ACK_TIMEOUT_EN enables the ack watchdog.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned                    NUM_OUTPUTS        = 4,
  parameter int unsigned                    DELAY_W            = 16,
  parameter logic [NUM_OUTPUTS*DELAY_W-1:0] STAGE_DELAYS       = '0,
  parameter int unsigned                    LOCK_FILTER_CYCLES = 16,
  parameter int unsigned                    SW_RST_MIN_CYCLES  = 8,
  parameter int unsigned                    ACK_TIMEOUT_CYCLES = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_ext_arst_n,
  input  logic                   i_pll_locked,
  input  logic                   i_sw_rst_req,
  input  logic [NUM_OUTPUTS-1:0] i_stage_ack,
  output logic [NUM_OUTPUTS-1:0] o_sync_resets,
  output logic                   o_all_released,
  output logic [2:0]             o_state,
  output logic                   o_fault,
  output logic [STAGE_W-1:0]     o_fault_stage
);

`ifdef RESET_SEQ_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int unsigned LOCK_W = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam int unsigned AS_W   = $clog2(SW_RST_MIN_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(ACK_TIMEOUT_CYCLES + 1);
  localparam int unsigned DLY_W  = DELAY_W + 1;

  logic rst_int_n;
  logic lock_s;

  cdc_sync2 #(.RST_VAL(1'b0)) u_arst_sync (
    .i_clk    (i_clk),
    .i_arst_n (i_ext_arst_n),
    .d        (1'b1),
    .q        (rst_int_n)
  );

  // Reset by the raw board reset so lock_s is settled when the core leaves reset.
  cdc_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .i_clk    (i_clk),
    .i_arst_n (i_ext_arst_n),
    .d        (i_pll_locked),
    .q        (lock_s)
  );

  reset_seq_state_t        state_q, state_d;
  logic [NUM_OUTPUTS-1:0]  rst_q, rst_d;
  logic [STAGE_W-1:0]      stage_q, stage_d;
  logic [LOCK_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic [DLY_W-1:0]        dly_cnt_q, dly_cnt_d;
  logic [AS_W-1:0]         as_cnt_q, as_cnt_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic                    fault_q, fault_d;
  logic [STAGE_W-1:0]      fault_stage_q, fault_stage_d;
  logic                    rel_q;

  logic [DELAY_W-1:0]      stage_dly;
  logic                    stage_ack;
  logic [NUM_OUTPUTS-1:0]  stage_mask;
  logic                    last_stage;
  logic                    abort;

  always_comb begin
    stage_dly  = '0;
    stage_ack  = 1'b0;
    stage_mask = '0;
    for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
      if (stage_q == STAGE_W'(i)) begin
        stage_dly     = STAGE_DELAYS[i*DELAY_W +: DELAY_W];
        stage_ack     = i_stage_ack[i];
        stage_mask[i] = 1'b1;
      end
    end
  end

  assign last_stage = (stage_q == STAGE_W'(NUM_OUTPUTS - 1));
  assign abort      = !lock_s || i_sw_rst_req;

  always_comb begin
    state_d       = state_q;
    rst_d         = rst_q;
    stage_d       = stage_q;
    lock_cnt_d    = lock_cnt_q;
    dly_cnt_d     = dly_cnt_q;
    as_cnt_d      = as_cnt_q;
    to_cnt_d      = to_cnt_q;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;

    if (abort && (state_q == DELAY || state_q == WAIT_ACK || state_q == RUN)) begin
      state_d  = ASSERT;
      rst_d    = '1;
      as_cnt_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          rst_d     = '1;
          stage_d   = '0;
          dly_cnt_d = '0;
          if (abort) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q == LOCK_W'(LOCK_FILTER_CYCLES - 1)) begin
            lock_cnt_d = '0;
            state_d    = DELAY;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        DELAY: begin
          // D+1 cycles in DELAY: counter runs 0..D, release on the D cycle.
          if (dly_cnt_q == {1'b0, stage_dly}) begin
            rst_d     = rst_q & ~stage_mask;
            dly_cnt_d = '0;
            to_cnt_d  = '0;
            state_d   = WAIT_ACK;
          end else begin
            dly_cnt_d = dly_cnt_q + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (stage_ack) begin
            if (last_stage) begin
              state_d = RUN;
            end else begin
              stage_d = stage_q + 1'b1;
              state_d = DELAY;
            end
          end else if (TO_EN && to_cnt_q == TO_W'(ACK_TIMEOUT_CYCLES - 1)) begin
            fault_d       = 1'b1;
            fault_stage_d = stage_q;
            state_d       = ASSERT;
            rst_d         = '1;
            as_cnt_d      = '0;
          end else if (TO_EN) begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        RUN: begin
        end
        ASSERT: begin
          rst_d      = '1;
          lock_cnt_d = '0;
          if (i_sw_rst_req) begin
            as_cnt_d = '0;
          end else if (as_cnt_q == AS_W'(SW_RST_MIN_CYCLES - 1)) begin
            as_cnt_d = '0;
            state_d  = HOLD;
          end else begin
            as_cnt_d = as_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = HOLD;
          rst_d   = '1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= HOLD;
      rst_q         <= '1;
      stage_q       <= '0;
      lock_cnt_q    <= '0;
      dly_cnt_q     <= '0;
      as_cnt_q      <= '0;
      to_cnt_q      <= '0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
      rel_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_q         <= rst_d;
      stage_q       <= stage_d;
      lock_cnt_q    <= lock_cnt_d;
      dly_cnt_q     <= dly_cnt_d;
      as_cnt_q      <= as_cnt_d;
      to_cnt_q      <= to_cnt_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
      rel_q         <= (state_d == RUN);
    end
  end

  assign o_sync_resets  = rst_q;
  assign o_all_released = rel_q;
  assign o_state        = state_q;
  assign o_fault        = TO_EN ? fault_q : 1'b0;
  assign o_fault_stage  = TO_EN ? fault_stage_q : '0;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: N=3, D={2,0,5}, lock filter 4, 8-cycle ASSERT, 64-cycle ack timeout.
module tb_reset_sequencer;

  localparam logic [2:0] S_HOLD   = 3'd0;
  localparam logic [2:0] S_DELAY  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_ASSERT = 3'd4;

  logic       i_clk        = 1'b0;
  logic       i_ext_arst_n = 1'b0;
  logic       i_pll_locked = 1'b1;
  logic       i_sw_rst_req = 1'b0;
  logic [2:0] i_stage_ack  = 3'b111;
  logic [2:0] o_sync_resets;
  logic       o_all_released;
  logic [2:0] o_state;
  logic       o_fault;
  logic [3:0] o_fault_stage;

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  logic       exp_f  = 1'b0;
  logic [3:0] exp_fs = 4'd0;

  reset_sequencer #(
    .NUM_OUTPUTS        (3),
    .DELAY_W            (16),
    .STAGE_DELAYS       ({16'd5, 16'd0, 16'd2}),
    .LOCK_FILTER_CYCLES (4),
    .SW_RST_MIN_CYCLES  (8),
    .ACK_TIMEOUT_CYCLES (64)
  ) dut (
    .i_clk          (i_clk),
    .i_ext_arst_n   (i_ext_arst_n),
    .i_pll_locked   (i_pll_locked),
    .i_sw_rst_req   (i_sw_rst_req),
    .i_stage_ack    (i_stage_ack),
    .o_sync_resets  (o_sync_resets),
    .o_all_released (o_all_released),
    .o_state        (o_state),
    .o_fault        (o_fault),
    .o_fault_stage  (o_fault_stage)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic       rel;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string name, input logic [2:0] er, input logic erel, input logic [2:0] est);
    checks++;
    if ({o_sync_resets, o_all_released, o_state, o_fault, o_fault_stage} !== {er, erel, est, exp_f, exp_fs}) begin
      errors++;
      $display("FAIL %s cyc=%0d: got rst=%b rel=%b st=%0d fault=%b fstage=%0d, want rst=%b rel=%b st=%0d fault=%b fstage=%0d",
               name, cyc, o_sync_resets, o_all_released, o_state, o_fault, o_fault_stage,
               er, erel, est, exp_f, exp_fs);
    end
  endtask

  initial begin
    // Cycle numbers count clock edges after i_ext_arst_n rises; acks all high.
    vecs = '{
      '{ 1, 3'b111, 1'b0, S_HOLD},
      '{ 2, 3'b111, 1'b0, S_HOLD},
      '{ 5, 3'b111, 1'b0, S_HOLD},
      '{ 6, 3'b111, 1'b0, S_DELAY},
      '{ 8, 3'b111, 1'b0, S_DELAY},
      '{ 9, 3'b110, 1'b0, S_WAIT},
      '{10, 3'b110, 1'b0, S_DELAY},
      '{11, 3'b100, 1'b0, S_WAIT},
      '{12, 3'b100, 1'b0, S_DELAY},
      '{17, 3'b100, 1'b0, S_DELAY},
      '{18, 3'b000, 1'b0, S_WAIT},
      '{19, 3'b000, 1'b1, S_RUN},
      '{25, 3'b000, 1'b1, S_RUN}
    };

    repeat (3) tick();
    chk("reset_state", 3'b111, 1'b0, S_HOLD);

    i_ext_arst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 13; i++) begin
      run_to(vecs[i].cyc);
      chk($sformatf("vec%0d", i), vecs[i].rst, vecs[i].rel, vecs[i].st);
    end

    // Lock loss in RUN: two synchroniser cycles, then ASSERT.
    i_pll_locked = 1'b0;
    run_to(27); chk("lockloss_sync", 3'b000, 1'b1, S_RUN);
    run_to(28); chk("lockloss_assert", 3'b111, 1'b0, S_ASSERT);
    i_pll_locked = 1'b1;
    run_to(35); chk("relock_assert_end", 3'b111, 1'b0, S_ASSERT);
    run_to(36); chk("relock_hold", 3'b111, 1'b0, S_HOLD);
    run_to(42); chk("relock_delay0", 3'b111, 1'b0, S_DELAY);
    run_to(43); chk("relock_rel0", 3'b110, 1'b0, S_WAIT);
    run_to(45); chk("relock_rel1", 3'b100, 1'b0, S_WAIT);
    run_to(52); chk("relock_rel2", 3'b000, 1'b0, S_WAIT);
    run_to(53); chk("relock_run", 3'b000, 1'b1, S_RUN);

    // One-cycle software request from RUN, stage 1 ack withheld afterwards.
    i_stage_ack  = 3'b101;
    i_sw_rst_req = 1'b1;
    tick();
    i_sw_rst_req = 1'b0;
    chk("sw_pulse_assert", 3'b111, 1'b0, S_ASSERT);
    run_to(61); chk("sw_pulse_last", 3'b111, 1'b0, S_ASSERT);
    run_to(62); chk("sw_pulse_hold", 3'b111, 1'b0, S_HOLD);
    run_to(71); chk("ack1_wait", 3'b100, 1'b0, S_WAIT);
    run_to(121); chk("ack1_held_50", 3'b100, 1'b0, S_WAIT);
    i_stage_ack = 3'b111;
    tick(); chk("ack1_delay2", 3'b100, 1'b0, S_DELAY);
    run_to(127); chk("delay2_end", 3'b100, 1'b0, S_DELAY);
    run_to(128); chk("delay2_rel", 3'b000, 1'b0, S_WAIT);
    run_to(129); chk("delay2_run", 3'b000, 1'b1, S_RUN);

    // Request held through 20 ASSERT cycles after the entry edge: 28 cycles total.
    i_stage_ack  = 3'b101;
    i_sw_rst_req = 1'b1;
    run_to(130); chk("sw_held_entry", 3'b111, 1'b0, S_ASSERT);
    run_to(150);
    i_sw_rst_req = 1'b0;
    run_to(157); chk("sw_held_last", 3'b111, 1'b0, S_ASSERT);
    run_to(158); chk("sw_held_hold", 3'b111, 1'b0, S_HOLD);

    // One-cycle request while waiting for stage 1.
    run_to(167); chk("wait1_again", 3'b100, 1'b0, S_WAIT);
    run_to(170);
    i_sw_rst_req = 1'b1;
    tick();
    i_sw_rst_req = 1'b0;
    chk("wait_sw_assert", 3'b111, 1'b0, S_ASSERT);
    run_to(178); chk("wait_sw_last", 3'b111, 1'b0, S_ASSERT);
    run_to(179); chk("wait_sw_hold", 3'b111, 1'b0, S_HOLD);
    run_to(188); chk("wait1_third", 3'b100, 1'b0, S_WAIT);

`ifdef RESET_SEQ_ACK_TIMEOUT_EN
    run_to(251); chk("pre_timeout", 3'b100, 1'b0, S_WAIT);
    run_to(252);
    exp_f  = 1'b1;
    exp_fs = 4'd1;
    chk("timeout_fault", 3'b111, 1'b0, S_ASSERT);
    run_to(260); chk("timeout_retry_hold", 3'b111, 1'b0, S_HOLD);
`else
    run_to(252); chk("no_timeout_64", 3'b100, 1'b0, S_WAIT);
    run_to(262); chk("no_timeout_74", 3'b100, 1'b0, S_WAIT);
`endif

    // Reach stage 2 DELAY, then pull the board reset asynchronously.
    run_to(262);
    i_stage_ack = 3'b111;
    for (int i = 0; i < 40; i++) begin
      if (!(o_state == S_DELAY && o_sync_resets == 3'b100)) tick();
    end
    chk("reach_delay2", 3'b100, 1'b0, S_DELAY);
    tick();
    tick();
    i_ext_arst_n = 1'b0;
    #1;
    exp_f  = 1'b0;
    exp_fs = 4'd0;
    chk("arst_mid_delay", 3'b111, 1'b0, S_HOLD);
    tick();
    tick();
    i_ext_arst_n = 1'b1;
    tick();
    tick();
    chk("post_release_hold", 3'b111, 1'b0, S_HOLD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
